alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_rr.sv | 20 ++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM encoding, ALU opcode values
// and a small helper turning a requester index into a per-requester mask.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_NOTA  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_NEGA  = 3'b110;
  localparam logic [2:0] OP_NEGB  = 3'b111;

  function automatic logic [1:0] idx_to_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant: when both request, the one not served last
// wins; a lone requester always wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    any = |req;
    gnt = 1'b0;
    if (req == 2'b11) begin
      gnt = ~last;
    end else if (req[1]) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: round-robin accept,
// registered operands, one-cycle execute, then held response handshake.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero
);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             arb_gnt;
  logic             arb_any;

  rr_arbiter2 u_rr (
    .req  (req_valid),
    .last (last_q),
    .gnt  (arb_gnt),
    .any  (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_y_d    = rsp_y_q;
    rsp_zero_d = rsp_zero_q;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = idx_to_mask(arb_gnt);
          gnt_d     = arb_gnt;
          alu_a_d   = arb_gnt ? req_a1  : req_a0;
          alu_b_d   = arb_gnt ? req_b1  : req_b0;
          alu_op_d  = arb_gnt ? req_op1 : req_op0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_y_d    = alu_y;
        rsp_zero_d = alu_zero;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = idx_to_mask(gnt_q);
        // The loser's rsp_ready is deliberately ignored here.
        if (rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_y_q    <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_y_q    <= rsp_y_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_y    = rsp_y_q;
  assign rsp_zero = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU alongside; table of
// single operations plus hand-written backpressure and mid-operation reset runs.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a0, req_a1, req_b0, req_b1;
  logic [2:0]  req_op0, req_op1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_y;
  logic        rsp_zero;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_y;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero)
  );

  // External ALU that sits next to the arbiter in the datapath.
  always_comb begin
    alu_y = 16'h0000;
    case (alu_op)
      OP_PASSA: alu_y = alu_a;
      OP_NOTA:  alu_y = ~alu_a;
      OP_ADD:   alu_y = alu_a + alu_b;
      OP_SUB:   alu_y = alu_a - alu_b;
      OP_AND:   alu_y = alu_a & alu_b;
      OP_OR:    alu_y = alu_a | alu_b;
      OP_NEGA:  alu_y = 16'h0000 - alu_a;
      OP_NEGB:  alu_y = 16'h0000 - alu_b;
      default:  alu_y = 16'h0000;
    endcase
    alu_zero = (alu_y == 16'h0000);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the schedule ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        do_reset;
    logic [1:0]  valid;
    logic [15:0] a0, b0;
    logic [2:0]  op0;
    logic [15:0] a1, b1;
    logic [2:0]  op1;
    logic        gnt;
    logic [15:0] y;
    logic        zero;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete operation: accept in IDLE, check EXEC, check RESP; the
  // handshake completes on the following edge since rsp_ready is high.
  task automatic applyStimulus(input int idx, input vec_t v);
    logic [1:0] mask;
    mask = v.gnt ? 2'b10 : 2'b01;
    @(negedge clk);
    req_valid = v.valid;
    req_a0 = v.a0; req_b0 = v.b0; req_op0 = v.op0;
    req_a1 = v.a1; req_b1 = v.b1; req_op1 = v.op1;
    rsp_ready = 2'b11;
    #1;
    checkOutput($sformatf("v%0d accept req_ready", idx), {30'd0, req_ready}, {30'd0, mask});
    checkOutput($sformatf("v%0d accept rsp_valid", idx), {30'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput($sformatf("v%0d exec req_ready", idx), {30'd0, req_ready}, 32'd0);
    checkOutput($sformatf("v%0d exec rsp_valid", idx), {30'd0, rsp_valid}, 32'd0);
    checkOutput($sformatf("v%0d exec alu_a", idx), {16'd0, alu_a}, {16'd0, v.gnt ? v.a1 : v.a0});
    checkOutput($sformatf("v%0d exec alu_b", idx), {16'd0, alu_b}, {16'd0, v.gnt ? v.b1 : v.b0});
    checkOutput($sformatf("v%0d exec alu_op", idx), {29'd0, alu_op}, {29'd0, v.gnt ? v.op1 : v.op0});
    @(negedge clk);
    #1;
    checkOutput($sformatf("v%0d resp rsp_valid", idx), {30'd0, rsp_valid}, {30'd0, mask});
    checkOutput($sformatf("v%0d resp rsp_y", idx), {16'd0, rsp_y}, {16'd0, v.y});
    checkOutput($sformatf("v%0d resp rsp_zero", idx), {31'd0, rsp_zero}, {31'd0, v.zero});
    checkOutput($sformatf("v%0d resp req_ready", idx), {30'd0, req_ready}, 32'd0);
  endtask

  initial begin
    vec_t v;

    vecs[0] = '{1'b0, 2'b01, 16'd5, 16'd3, OP_ADD, 16'd0, 16'd0, OP_PASSA, 1'b0, 16'd8, 1'b0};
    vecs[1] = '{1'b0, 2'b10, 16'd0, 16'd0, OP_PASSA, 16'h0007, 16'h0007, OP_SUB, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{1'b1, 2'b11, 16'h00F0, 16'h000F, OP_OR, 16'hFFFF, 16'h1234, OP_AND, 1'b0, 16'h00FF, 1'b0};
    vecs[3] = '{1'b0, 2'b11, 16'h00F0, 16'h000F, OP_OR, 16'hFFFF, 16'h1234, OP_AND, 1'b1, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 2'b11, 16'h00FF, 16'h0000, OP_NOTA, 16'h0000, 16'h0001, OP_NEGB, 1'b0, 16'hFF00, 1'b0};
    vecs[5] = '{1'b0, 2'b11, 16'h0000, 16'h0000, OP_NEGA, 16'h0000, 16'h0001, OP_NEGB, 1'b1, 16'hFFFF, 1'b0};
    vecs[6] = '{1'b0, 2'b11, 16'h0000, 16'h0000, OP_NEGA, 16'hBEEF, 16'h0000, OP_PASSA, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{1'b0, 2'b11, 16'hFFFF, 16'h0001, OP_ADD, 16'hBEEF, 16'h0000, OP_PASSA, 1'b1, 16'hBEEF, 1'b0};
    vecs[8] = '{1'b0, 2'b11, 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 16'h0001, OP_SUB, 1'b0, 16'h0000, 1'b1};
    vecs[9] = '{1'b0, 2'b11, 16'h1111, 16'h2222, OP_AND, 16'h0000, 16'h0001, OP_SUB, 1'b1, 16'hFFFF, 1'b0};

    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("reset req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("reset alu_a", {16'd0, alu_a}, 32'd0);
    checkOutput("reset alu_op", {29'd0, alu_op}, 32'd0);
    checkOutput("reset rsp_y", {16'd0, rsp_y}, 32'd0);
    checkOutput("reset rsp_zero", {31'd0, rsp_zero}, 32'd0);
    rst_n = 1'b1;
    $display("[TB] reset released, running vector table");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_reset) doReset();
      applyStimulus(i, vecs[i]);
    end

    // Backpressure: req0 held in RESP while req1 waits; req1's rsp_ready high must not complete it.
    $display("[TB] backpressure sequence");
    @(negedge clk);
    req_valid = 2'b01;
    req_a0 = 16'h0001; req_b0 = 16'h0002; req_op0 = OP_ADD;
    rsp_ready = 2'b10;
    #1;
    checkOutput("bp accept req_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b10;
    req_a1 = 16'h000A; req_b1 = 16'h0050; req_op1 = OP_OR;
    #1;
    checkOutput("bp exec req_ready", {30'd0, req_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("bp hold%0d rsp_valid", k), {30'd0, rsp_valid}, 32'd1);
      checkOutput($sformatf("bp hold%0d rsp_y", k), {16'd0, rsp_y}, 32'd3);
      checkOutput($sformatf("bp hold%0d req_ready", k), {30'd0, req_ready}, 32'd0);
      checkOutput($sformatf("bp hold%0d alu_a", k), {16'd0, alu_a}, 32'd1);
    end
    @(negedge clk);
    rsp_ready = 2'b11;
    #1;
    checkOutput("bp release rsp_valid", {30'd0, rsp_valid}, 32'd1);
    checkOutput("bp release req_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("bp req1 accept req_ready", {30'd0, req_ready}, 32'd2);
    checkOutput("bp req1 accept rsp_valid", {30'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checkOutput("bp req1 alu_a", {16'd0, alu_a}, 32'h000A);
    checkOutput("bp req1 alu_op", {29'd0, alu_op}, {29'd0, OP_OR});
    @(negedge clk);
    #1;
    checkOutput("bp req1 rsp_valid", {30'd0, rsp_valid}, 32'd2);
    checkOutput("bp req1 rsp_y", {16'd0, rsp_y}, 32'h005A);

    // Mid-operation reset: first leave last=0 so a surviving pointer would favour req1.
    $display("[TB] mid-operation reset sequence");
    v = '{1'b0, 2'b01, 16'h1357, 16'h0000, OP_PASSA, 16'h0000, 16'h0000, OP_PASSA, 1'b0, 16'h1357, 1'b0};
    applyStimulus(10, v);
    @(negedge clk);
    req_valid = 2'b01;
    req_a0 = 16'h0102; req_b0 = 16'h0000; req_op0 = OP_ADD;
    #1;
    checkOutput("rst accept req_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checkOutput("rst exec alu_a", {16'd0, alu_a}, 32'h0102);
    rst_n = 1'b0;
    #1;
    checkOutput("rst async rsp_valid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("rst async req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst async alu_a", {16'd0, alu_a}, 32'd0);
    checkOutput("rst async alu_op", {29'd0, alu_op}, 32'd0);
    checkOutput("rst async rsp_y", {16'd0, rsp_y}, 32'd0);
    checkOutput("rst async rsp_zero", {31'd0, rsp_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("rst after%0d rsp_valid", k), {30'd0, rsp_valid}, 32'd0);
    end
    v = '{1'b0, 2'b11, 16'h0009, 16'h0004, OP_SUB, 16'h0001, 16'h0001, OP_ADD, 1'b0, 16'h0005, 1'b0};
    applyStimulus(11, v);

    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
